// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock divider with glitch-free divisor reload
module clk_div_prog #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 7,
  parameter int CH_SEL_W    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [CH_SEL_W-1:0] i_ch_sel,
  input  logic [DIV_W-1:0]    i_div,
  input  logic                i_sync,
  output logic [NUM_CH-1:0]   o_clk,
  output logic [NUM_CH-1:0]   o_tick,
  output logic [NUM_CH-1:0]   o_pend
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, pdiv_q, pdiv_d;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
    logic             hit, bnd, slow, apply;
    always_comb begin
      hit    = i_load && i_ch_sel == CH_SEL_W'(c);
      slow   = act_q > DIV_W'(1);
      bnd    = act_q != '0 && cnt_q == act_q - DIV_W'(1);
      apply  = i_sync || (pend_q && (bnd || !slow));
      clk_d  = slow && cnt_q < act_q - (act_q >> 1);
      tick_d = bnd;
      cnt_d  = (apply || bnd || !slow) ? '0 : cnt_q + DIV_W'(1);
      // a load coinciding with sync bypasses the pending slot
      act_d  = (i_sync && hit) ? i_div : (apply && pend_q) ? pdiv_q : act_q;
      pend_d = (i_sync && hit) ? 1'b0 : (hit || (pend_q && !apply));
      pdiv_d = hit ? i_div : pdiv_q;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt_q  <= '0;
        act_q  <= DIV_W'(DEFAULT_DIV);
        pdiv_q <= '0;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        pdiv_q <= pdiv_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end
    assign o_clk[c]  = clk_q;
    assign o_tick[c] = tick_q;
    assign o_pend[c] = pend_q;
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: vector table, directed corner sequences and random traffic against a period model
module tb_clk_div_prog;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic              i_clk = 0, i_rst = 1, i_load = 0, i_sync = 0;
  logic [1:0]        i_ch_sel = 0;
  logic [DIV_W-1:0]  i_div = 0;
  logic [NUM_CH-1:0] o_clk, o_tick, o_pend;
  logic [2:0]        s_clk, s_tick, s_pend;
  int errors = 0, checks = 0;

  // model: position within the current period and the period length per channel
  int                m_pos[NUM_CH], m_n[NUM_CH], m_pd[NUM_CH];
  bit                m_pf[NUM_CH];
  logic [NUM_CH-1:0] e_clk, e_tick, e_pend;

  typedef struct {
    bit ld; int sel; int dv; bit sy;
    logic [3:0] clk; logic [3:0] tick; logic [3:0] pend;
  } vec_t;
  vec_t tbl[15];

  clk_div_prog u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_ch_sel(i_ch_sel),
    .i_div(i_div), .i_sync(i_sync), .o_clk(o_clk), .o_tick(o_tick), .o_pend(o_pend)
  );

  // three-channel copy: select value 3 is out of range here and must be ignored
  clk_div_prog #(.NUM_CH(3)) u_odd (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_ch_sel(i_ch_sel),
    .i_div(i_div), .i_sync(i_sync), .o_clk(s_clk), .o_tick(s_tick), .o_pend(s_pend)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c] = 0; m_n[c] = 7; m_pd[c] = 0; m_pf[c] = 0;
    end
    e_clk = '0; e_tick = '0; e_pend = '0;
  endtask

  task automatic model_edge(input bit ld, input int sel, input int dv, input bit sy);
    for (int c = 0; c < NUM_CH; c++) begin
      int n;
      bit last, mine;
      n = m_n[c];
      last = n > 0 && m_pos[c] == n - 1;
      mine = ld && sel == c;
      e_clk[c]  = n >= 2 && m_pos[c] < (n + 1) / 2;
      e_tick[c] = last;
      if (sy) begin
        m_pos[c] = 0;
        if (mine) begin m_n[c] = dv; m_pf[c] = 0; end
        else if (m_pf[c]) begin m_n[c] = m_pd[c]; m_pf[c] = 0; end
      end else if (m_pf[c] && (last || n < 2)) begin
        m_n[c] = m_pd[c]; m_pos[c] = 0; m_pf[c] = mine;
        if (mine) m_pd[c] = dv;
      end else begin
        m_pos[c] = (last || n < 2) ? 0 : m_pos[c] + 1;
        if (mine) begin m_pd[c] = dv; m_pf[c] = 1; end
      end
      e_pend[c] = m_pf[c];
    end
  endtask

  task automatic check_all();
    chk("clk", int'(o_clk), int'(e_clk));
    chk("tick", int'(o_tick), int'(e_tick));
    chk("pend", int'(o_pend), int'(e_pend));
    chk("odd_clk", int'(s_clk), int'(e_clk[2:0]));
    chk("odd_tick", int'(s_tick), int'(e_tick[2:0]));
    chk("odd_pend", int'(s_pend), int'(e_pend[2:0]));
  endtask

  task automatic step(input bit ld, input int sel, input int dv, input bit sy);
    i_load = ld; i_ch_sel = 2'(sel); i_div = DIV_W'(dv); i_sync = sy;
    @(posedge i_clk);
    model_edge(ld, sel, dv, sy);
    @(negedge i_clk);
    i_load = 0; i_sync = 0;
    check_all();
  endtask

  initial begin
    int n, hi, tk;
    tbl[0]  = '{0, 0, 0, 0, 4'hF, 4'h0, 4'h0};
    tbl[1]  = '{0, 0, 0, 0, 4'hF, 4'h0, 4'h0};
    tbl[2]  = '{1, 1, 4, 0, 4'hF, 4'h0, 4'h2};
    tbl[3]  = '{0, 0, 0, 0, 4'hF, 4'h0, 4'h2};
    tbl[4]  = '{0, 0, 0, 0, 4'h0, 4'h0, 4'h2};
    tbl[5]  = '{0, 0, 0, 0, 4'h0, 4'h0, 4'h2};
    tbl[6]  = '{0, 0, 0, 0, 4'h0, 4'hF, 4'h0};
    tbl[7]  = '{0, 0, 0, 0, 4'hF, 4'h0, 4'h0};
    tbl[8]  = '{0, 0, 0, 0, 4'hF, 4'h0, 4'h0};
    tbl[9]  = '{0, 0, 0, 0, 4'hD, 4'h0, 4'h0};
    tbl[10] = '{0, 0, 0, 0, 4'hD, 4'h2, 4'h0};
    tbl[11] = '{0, 0, 0, 0, 4'h2, 4'h0, 4'h0};
    tbl[12] = '{0, 0, 0, 0, 4'h2, 4'h0, 4'h0};
    tbl[13] = '{0, 0, 0, 0, 4'h0, 4'hD, 4'h0};
    tbl[14] = '{0, 0, 0, 0, 4'hD, 4'h2, 4'h0};
    model_reset();
    #2;
    chk("reset_out", int'({o_clk, o_tick, o_pend}), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 0;

    // default ratio, then ch1 reloaded to 4 mid-period
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].ld, tbl[i].sel, tbl[i].dv, tbl[i].sy);
      chk($sformatf("tbl%0d_clk", i), int'(o_clk), int'(tbl[i].clk));
      chk($sformatf("tbl%0d_tick", i), int'(o_tick), int'(tbl[i].tick));
      chk($sformatf("tbl%0d_pend", i), int'(o_pend), int'(tbl[i].pend));
    end

    // stop ch2, then full rate
    step(1, 2, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("stop_clk2", int'(o_clk[2]), 0);
    chk("stop_tick2", int'(o_tick[2]), 0);
    step(1, 2, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("full_tick2", int'(o_tick[2]), 1);
      chk("full_clk2", int'(o_clk[2]), 0);
      step(0, 0, 0, 0);
    end

    // sync with a coinciding load to ch3
    step(1, 0, 5, 0);
    step(1, 3, 6, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0);
    step(1, 3, 3, 1);
    chk("sync_pend", int'(o_pend), 0);
    step(0, 0, 0, 0);
    chk("sync_rise0", int'(o_clk[0]), 1);
    chk("sync_rise3", int'(o_clk[3]), 1);
    step(0, 0, 0, 0);
    chk("sync_c3_b", int'({o_clk[3], o_tick[3]}), 2);
    step(0, 0, 0, 0);
    chk("sync_c3_c", int'({o_clk[3], o_tick[3]}), 1);

    // last load wins: ch1 ends up dividing by 10
    step(1, 1, 9, 0);
    step(1, 1, 10, 0);
    n = 0;
    while (o_pend[1] && n < 12) begin step(0, 0, 0, 0); n++; end
    chk("lastwins_bound", int'(o_pend[1]), 0);
    hi = 0; tk = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      hi += int'(o_clk[1]); tk += int'(o_tick[1]);
    end
    chk("lastwins_high", hi, 5);
    chk("lastwins_tick", tk, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 11),
           $urandom_range(0, 39) == 0);

    // asynchronous reset while ch0 is high with a load pending
    step(1, 0, 9, 0);
    n = 0;
    while (!o_clk[0] && n < 20) begin step(1, 0, 9, 0); n++; end
    chk("rst_pre_clk0", int'(o_clk[0]), 1);
    chk("rst_pre_pend0", int'(o_pend[0]), 1);
    #2 i_rst = 1;
    #1;
    chk("rst_async", int'({o_clk, o_tick, o_pend}), 0);
    chk("rst_async_odd", int'({s_clk, s_tick, s_pend}), 0);
    model_reset();
    @(negedge i_clk);
    i_rst = 0;
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
